// File: rtl/gpg_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : gpg_spi_arbiter
//  Purpose  : Two-requester round-robin arbiter that turns a captured
//             (cmd, port, value) request into a 5-byte GoPiGo3 SPI frame
//             ADDR, cmd, port, val[15:8], val[7:0]. Each byte is handed to
//             an external SPI byte master through spi_start/spi_data, and
//             the block waits for that master's spi_busy to rise and fall.
//             Slave select is framed by a setup and a hold interval. A busy
//             line that never rises aborts the frame.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req/cmd/port/val  - requester 0 and 1 inputs
//             ack0, ack1, err   - one-cycle completion / abort pulses
//             gnt, active       - granted requester, frame in progress
//             ssbar             - SPI slave select (active low)
//             spi_start/data    - byte-send handshake to the SPI master
//             spi_busy          - SPI byte master busy
//  Revision : 1.0 - initial release
// ============================================================================
module gpg_spi_arbiter #(
  parameter logic [7:0] ADDR        = 8'h08,
  parameter int         STARTUP_CYC = 500,
  parameter int         SS_SETUP    = 64,
  parameter int         SS_HOLD     = 12,
  parameter int         BUSY_TO     = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  port0,
  input  logic [15:0] val0,
  input  logic        req1,
  input  logic [7:0]  cmd1,
  input  logic [7:0]  port1,
  input  logic [15:0] val1,
  output logic        ack0,
  output logic        ack1,
  output logic        err,
  output logic        gnt,
  output logic        active,
  output logic        ssbar,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  input  logic        spi_busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_HOLD      = 3'd5,
    ST_ABORT     = 3'd6
  } state_t;

  // Startup counter runs 0 .. STARTUP_CYC-1 and then parks.
  localparam int c_su_w = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;
  localparam logic [c_su_w-1:0] c_su_last = c_su_w'(STARTUP_CYC - 1);
  localparam logic [c_su_w-1:0] c_su_one  = c_su_w'(1);

  // One shared interval counter serves SETUP, HOLD and the busy timeout.
  localparam int c_cnt_max = (SS_SETUP > SS_HOLD)
                             ? ((SS_SETUP > BUSY_TO) ? SS_SETUP : BUSY_TO)
                             : ((SS_HOLD  > BUSY_TO) ? SS_HOLD  : BUSY_TO);
  localparam int c_cnt_w = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_setup_last = c_cnt_w'(SS_SETUP - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last  = c_cnt_w'(SS_HOLD - 1);
  localparam logic [c_cnt_w-1:0] c_busy_last  = c_cnt_w'(BUSY_TO - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  state_t              state_q, state_d;
  logic [c_su_w-1:0]   su_cnt_q, su_cnt_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          port_q, port_d;
  logic [15:0]         val_q, val_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                ssbar_q, ssbar_d;
  logic                spi_start_q, spi_start_d;
  logic [7:0]          spi_data_q, spi_data_d;
  logic                ack0_q, ack0_d;
  logic                ack1_q, ack1_d;
  logic                err_q, err_d;
  logic                active_q, active_d;

  logic                su_done;
  logic                win;
  logic [7:0]          byte_sel;

  assign su_done = (su_cnt_q == c_su_last);
  // On a tie the requester that was not served last wins; otherwise the
  // only active requester wins.
  assign win     = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    state_d  = state_q;
    su_cnt_d = su_cnt_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    cmd_d    = cmd_q;
    port_d   = port_q;
    val_d    = val_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err_d    = 1'b0;
    byte_sel = 8'h00;

    if (!su_done) begin
      su_cnt_d = su_cnt_q + c_su_one;
    end

    case (state_q)
      ST_IDLE: begin
        idx_d = 3'd0;
        cnt_d = '0;
        if (su_done && (req0 | req1)) begin
          gnt_d   = win;
          last_d  = win;
          cmd_d   = win ? cmd1  : cmd0;
          port_d  = win ? port1 : port0;
          val_d   = win ? val1  : val0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == c_setup_last) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_SEND: begin
        cnt_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // Busy is checked as a level, so a master that is already busy in
        // the SEND cycle is accepted on the first WAIT_BUSY cycle.
        if (spi_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == c_busy_last) begin
          state_d = ST_ABORT;
          err_d   = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_WAIT_DONE: begin
        if (!spi_busy) begin
          if (idx_q < 3'd4) begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end else begin
            idx_d   = 3'd0;
            cnt_d   = '0;
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == c_hold_last) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end
      ST_ABORT: begin
        idx_d   = 3'd0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = 3'd0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Byte selected by the index the next state will use; only driven out
    // while a SEND cycle is coming up.
    case (idx_d)
      3'd0:    byte_sel = ADDR;
      3'd1:    byte_sel = cmd_q;
      3'd2:    byte_sel = port_q;
      3'd3:    byte_sel = val_q[15:8];
      3'd4:    byte_sel = val_q[7:0];
      default: byte_sel = 8'h00;
    endcase

    // Outputs are decoded from the next state so the registered versions
    // line up exactly with the registered state.
    ssbar_d     = (state_d == ST_IDLE) || (state_d == ST_ABORT);
    spi_start_d = (state_d == ST_SEND);
    spi_data_d  = spi_start_d ? byte_sel : 8'h00;
    active_d    = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      su_cnt_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      cmd_q       <= 8'h00;
      port_q      <= 8'h00;
      val_q       <= 16'h0000;
      gnt_q       <= 1'b0;
      last_q      <= 1'b1;  // requester 0 wins the first tie
      ssbar_q     <= 1'b1;
      spi_start_q <= 1'b0;
      spi_data_q  <= 8'h00;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      su_cnt_q    <= su_cnt_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      port_q      <= port_d;
      val_q       <= val_d;
      gnt_q       <= gnt_d;
      last_q      <= last_d;
      ssbar_q     <= ssbar_d;
      spi_start_q <= spi_start_d;
      spi_data_q  <= spi_data_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err_q       <= err_d;
      active_q    <= active_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign err       = err_q;
  assign gnt       = gnt_q;
  assign active    = active_q;
  assign ssbar     = ssbar_q;
  assign spi_start = spi_start_q;
  assign spi_data  = spi_data_q;

endmodule
`default_nettype wire

// File: tb/tb_gpg_spi_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpg_spi_arbiter
//  Purpose  : Self-checking bench for gpg_spi_arbiter. A behavioural SPI
//             byte master answers each spi_start (busy rises 2 cycles later
//             and stays high 16 cycles). Expected bytes and acks are queued
//             when a request is driven and compared as the DUT produces them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gpg_spi_arbiter;

  localparam logic [7:0] P_ADDR  = 8'h08;
  localparam int P_STARTUP = 500;
  localparam int P_SETUP   = 64;
  localparam int P_HOLD    = 12;
  localparam int P_BUSYTO  = 255;

  typedef struct {logic [7:0] data; logic gnt;} byte_exp_t;
  typedef struct {logic idx; logic err;} ack_exp_t;

  logic        clk, rst;
  logic        req0, req1;
  logic [7:0]  cmd0, port0, cmd1, port1;
  logic [15:0] val0, val1;
  logic        ack0, ack1, err, gnt, active, ssbar, spi_start, spi_busy;
  logic [7:0]  spi_data;

  gpg_spi_arbiter #(
    .ADDR(P_ADDR), .STARTUP_CYC(P_STARTUP), .SS_SETUP(P_SETUP),
    .SS_HOLD(P_HOLD), .BUSY_TO(P_BUSYTO)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .port0(port0), .val0(val0),
    .req1(req1), .cmd1(cmd1), .port1(port1), .val1(val1),
    .ack0(ack0), .ack1(ack1), .err(err), .gnt(gnt), .active(active),
    .ssbar(ssbar), .spi_start(spi_start), .spi_data(spi_data),
    .spi_busy(spi_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;

  byte_exp_t byte_q[$];
  ack_exp_t  ack_q[$];

  // Monitor / SPI model state
  int  cyc = 0;
  int  dly_cnt = 0, busy_cnt = 0;
  int  low_run = 0, high_run = 0, last_high = 0, frame_bytes = 0;
  int  first_fall_cyc = -1, start_cyc = 0, busy_fall_cyc = 0, bytes_seen = 0;
  bit  prev_ssbar = 1'b1;
  bit  no_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // SPI byte master model plus output scoreboard
  always @(negedge clk) begin
    byte_exp_t be;
    ack_exp_t  ae;
    if (rst) begin
      spi_busy       = 1'b0;
      dly_cnt        = 0;
      busy_cnt       = 0;
      low_run        = 0;
      high_run       = 0;
      frame_bytes    = 0;
      first_fall_cyc = -1;
      prev_ssbar     = 1'b1;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          spi_busy      = 1'b0;
          busy_fall_cyc = cyc;
        end
      end else if (dly_cnt > 0) begin
        dly_cnt--;
        if (dly_cnt == 0) begin
          spi_busy = 1'b1;
          busy_cnt = 16;
        end
      end

      if (!spi_start) begin
        check("spi_data_idle", {24'h0, spi_data}, 32'h0);
      end else begin
        if (!no_busy) dly_cnt = 2;
        start_cyc = cyc;
        bytes_seen++;
        check("start_ssbar", {31'h0, ssbar}, 32'h0);
        if (frame_bytes == 0) check("setup_len", low_run, P_SETUP);
        frame_bytes++;
        if (byte_q.size() == 0) begin
          check("byte_unexpected", byte_q.size(), 1);
        end else begin
          be = byte_q.pop_front();
          check("spi_data", {24'h0, spi_data}, {24'h0, be.data});
          check("gnt", {31'h0, gnt}, {31'h0, be.gnt});
        end
      end

      if (ack0 | ack1 | err) begin
        if (ack_q.size() == 0) begin
          check("ack_unexpected", ack_q.size(), 1);
        end else begin
          ae = ack_q.pop_front();
          check("ack_sel", {30'h0, ack1, ack0}, ae.idx ? 32'h2 : 32'h1);
          check("err", {31'h0, err}, {31'h0, ae.err});
          check("ack_ssbar", {31'h0, ssbar}, 32'h1);
          if (ae.err) check("timeout_len", cyc - start_cyc, P_BUSYTO + 1);
          else        check("hold_len", cyc - busy_fall_cyc, P_HOLD + 1);
        end
      end

      if (!ssbar) begin
        if (prev_ssbar) begin
          last_high = high_run;
          if (first_fall_cyc < 0) first_fall_cyc = cyc;
        end
        low_run++;
        high_run = 0;
      end else begin
        high_run++;
        low_run     = 0;
        frame_bytes = 0;
      end
      prev_ssbar = ssbar;
    end
  end

  task automatic push_frame(input logic g, input logic [7:0] c, input logic [7:0] p,
                            input logic [15:0] v);
    byte_q.push_back('{P_ADDR, g});
    byte_q.push_back('{c, g});
    byte_q.push_back('{p, g});
    byte_q.push_back('{v[15:8], g});
    byte_q.push_back('{v[7:0], g});
    ack_q.push_back('{g, 1'b0});
  endtask

  task automatic wait_ack(input int max_cyc);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (ack0 | ack1 | err) seen = 1'b1;
    end
    check("wait_ack", {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_active(input int max_cyc);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < max_cyc) begin
      @(negedge clk);
      n++;
      if (active) seen = 1'b1;
    end
    check("wait_active", {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_bytes(input int target, input int max_cyc);
    int n = 0;
    while (bytes_seen < target && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_bytes", {31'h0, bytes_seen >= target}, 32'h1);
  endtask

  task automatic wait_busy(input int max_cyc);
    int n = 0;
    while (!spi_busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("wait_busy", {31'h0, spi_busy}, 32'h1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = 8'h0E; port0 = 8'h03; val0 = 16'h03E8;
    cmd1 = 8'h00; port1 = 8'h00; val1 = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_ssbar", {31'h0, ssbar}, 32'h1);
    check("rst_start", {31'h0, spi_start}, 32'h0);
    check("rst_data", {24'h0, spi_data}, 32'h0);
    check("rst_acks", {29'h0, err, ack1, ack0}, 32'h0);
    check("rst_active", {31'h0, active}, 32'h0);
    check("rst_gnt", {31'h0, gnt}, 32'h0);

    // Single frame with req0 held from reset, then a back-to-back frame
    // because req0 is still high during the ack cycle.
    push_frame(1'b0, 8'h0E, 8'h03, 16'h03E8);
    push_frame(1'b0, 8'h0E, 8'h03, 16'h03E8);
    req0 = 1'b1;
    rst  = 1'b0;
    wait_ack(P_STARTUP + 1000);
    check("first_fall", first_fall_cyc, P_STARTUP);
    wait_active(5);
    @(negedge clk);
    check("gap_high", last_high, 1);
    // Inputs changed mid-frame must not reach the wire.
    val0 = 16'hFFFF; cmd0 = 8'hAA; port0 = 8'h55;
    req0 = 1'b0;
    wait_ack(1000);

    // Contention: requester 0 was served last, so 1 goes first and they
    // alternate.
    cmd0 = 8'h11; port0 = 8'h01; val0 = 16'h1234;
    cmd1 = 8'h22; port1 = 8'h02; val1 = 16'h5678;
    push_frame(1'b1, 8'h22, 8'h02, 16'h5678);
    push_frame(1'b0, 8'h11, 8'h01, 16'h1234);
    push_frame(1'b1, 8'h22, 8'h02, 16'h5678);
    push_frame(1'b0, 8'h11, 8'h01, 16'h1234);
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_ack(1000);
      if (k == 2) begin
        wait_active(5);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    check("idle_after", {31'h0, active}, 32'h0);

    // Busy timeout: only byte 0 goes out, then err+ack0 together.
    cmd0 = 8'h0E; port0 = 8'h03; val0 = 16'h03E8;
    no_busy = 1'b1;
    byte_q.push_back('{P_ADDR, 1'b0});
    ack_q.push_back('{1'b0, 1'b1});
    req0 = 1'b1;
    wait_ack(1000);
    check("to_err", {31'h0, err}, 32'h1);
    check("to_ack0", {31'h0, ack0}, 32'h1);
    req0 = 1'b0;
    no_busy = 1'b0;
    // Next frame must restart from byte 0.
    push_frame(1'b0, 8'h0E, 8'h03, 16'h03E8);
    req0 = 1'b1;
    wait_active(5);
    @(negedge clk);
    req0 = 1'b0;
    wait_ack(1000);

    // Reset in WAIT_DONE of byte 3: frame abandoned with no ack/err.
    base = bytes_seen;
    byte_q.push_back('{P_ADDR, 1'b0});
    byte_q.push_back('{8'h0E, 1'b0});
    byte_q.push_back('{8'h03, 1'b0});
    byte_q.push_back('{8'h03, 1'b0});
    req0 = 1'b1;
    wait_bytes(base + 4, 1000);
    wait_busy(10);
    @(negedge clk);
    check("pre_rst_active", {31'h0, active}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_ssbar", {31'h0, ssbar}, 32'h1);
    check("mid_rst_active", {31'h0, active}, 32'h0);
    check("mid_rst_acks", {29'h0, err, ack1, ack0}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    // Tie straight after reset: requester 0 first, then 1.
    push_frame(1'b0, 8'h0E, 8'h03, 16'h03E8);
    push_frame(1'b1, 8'h22, 8'h02, 16'h5678);
    req0 = 1'b1; req1 = 1'b1;
    rst = 1'b0;
    wait_ack(P_STARTUP + 1000);
    check("first_fall_rst", first_fall_cyc, P_STARTUP);
    wait_active(5);
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0;
    wait_ack(1000);
    repeat (3) @(negedge clk);

    check("bytes_left", byte_q.size(), 0);
    check("acks_left", ack_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
